// File: rtl/pixel_packet_receiver.sv
// Deserializes the inter-board dibit link into header/pixel/audio bytes and
// drives frame-buffer write strobes plus the optional audio byte stream.
module pixel_packet_receiver #(
    parameter int PIXELS_PER_PACKET = 320,
    parameter int AUDIO_BYTES       = 0,
    parameter int FRAME_PIXELS      = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic [16:0] pixel_addr,
    output logic [7:0]  pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  audio_data,
    output logic        audio_valid,
    output logic        packet_done,
    output logic        err_truncated,
    output logic        err_addr
);

    localparam int MAX_BYTES = (PIXELS_PER_PACKET > AUDIO_BYTES) ? PIXELS_PER_PACKET : AUDIO_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] LAST_PIXEL  = CNT_W'(PIXELS_PER_PACKET - 1);
    localparam logic [CNT_W-1:0] LAST_AUDIO  = (AUDIO_BYTES > 0) ? CNT_W'(AUDIO_BYTES - 1) : '0;
    localparam logic [23:0]      FRAME_LIMIT = 24'(FRAME_PIXELS);
    localparam logic [16:0]      LAST_ADDR   = 17'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PIXEL,
        AUDIO,
        DRAIN
    } state_t;

    state_t           state;
    logic [1:0]       dibit_cnt;
    logic [1:0]       hdr_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [16:0]      wr_addr;
    logic [5:0]       shift;
    logic [15:0]      hdr_hi;

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [23:0] header;
    logic        header_ok;

    // The first three dibits of a byte sit in shift as {d2,d1,d0}; the
    // dibit on the bus completes the byte on the fourth sample.
    assign rx_byte   = {axiid, shift};
    assign byte_done = axiiv && (dibit_cnt == 2'd3);
    assign header    = {hdr_hi, rx_byte};
    assign header_ok = (header[23:17] == 7'd0) && (header < FRAME_LIMIT);

    // NOTE: every register here is written with <= so all decisions in one
    // cycle see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        pixel_valid   <= 1'b0;
        audio_valid   <= 1'b0;
        packet_done   <= 1'b0;
        err_truncated <= 1'b0;
        err_addr      <= 1'b0;

        if (rst) begin
            state      <= IDLE;
            dibit_cnt  <= 2'd0;
            hdr_cnt    <= 2'd0;
            byte_cnt   <= '0;
            wr_addr    <= 17'd0;
            shift      <= 6'd0;
            hdr_hi     <= 16'd0;
            pixel_addr <= 17'd0;
            pixel_data <= 8'd0;
            audio_data <= 8'd0;
        end else begin
            if (axiiv) begin
                shift <= {axiid, shift[5:2]};
            end

            case (state)
                IDLE: begin
                    if (axiiv) begin
                        state     <= ADDR;
                        dibit_cnt <= 2'd1;
                        hdr_cnt   <= 2'd0;
                    end
                end

                ADDR, PIXEL, AUDIO: begin
                    if (!axiiv) begin
                        err_truncated <= 1'b1;
                        state         <= IDLE;
                        dibit_cnt     <= 2'd0;
                        hdr_cnt       <= 2'd0;
                        byte_cnt      <= '0;
                    end else begin
                        dibit_cnt <= dibit_cnt + 2'd1;
                        if (byte_done && state == ADDR) begin
                            hdr_hi  <= header[15:0];
                            hdr_cnt <= hdr_cnt + 2'd1;
                            if (hdr_cnt == 2'd2) begin
                                hdr_cnt <= 2'd0;
                                if (header_ok) begin
                                    state    <= PIXEL;
                                    wr_addr  <= header[16:0];
                                    byte_cnt <= '0;
                                end else begin
                                    err_addr <= 1'b1;
                                    state    <= DRAIN;
                                end
                            end
                        end else if (byte_done && state == PIXEL) begin
                            pixel_valid <= 1'b1;
                            pixel_addr  <= wr_addr;
                            pixel_data  <= rx_byte;
                            wr_addr     <= (wr_addr == LAST_ADDR) ? 17'd0 : wr_addr + 17'd1;
                            if (byte_cnt == LAST_PIXEL) begin
                                byte_cnt <= '0;
                                if (AUDIO_BYTES == 0) begin
                                    packet_done <= 1'b1;
                                    state       <= DRAIN;
                                end else begin
                                    state <= AUDIO;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + CNT_W'(1);
                            end
                        end else if (byte_done) begin
                            audio_valid <= 1'b1;
                            audio_data  <= rx_byte;
                            if (byte_cnt == LAST_AUDIO) begin
                                byte_cnt    <= '0;
                                packet_done <= 1'b1;
                                state       <= DRAIN;
                            end else begin
                                byte_cnt <= byte_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (!axiiv) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_packet_receiver.sv
// Drives the default receiver and a small audio-enabled receiver with directed
// and random packets, comparing strobes against an arithmetic packet model.
module tb_pixel_packet_receiver;

    localparam int FRAME = 76800;
    localparam int PIX0  = 320;
    localparam int AUD0  = 0;
    localparam int PIX1  = 8;
    localparam int AUD1  = 4;

    logic clk = 1'b0;
    logic rst;
    logic v0, v1;
    logic [1:0] d0, d1;

    logic [16:0] pa0, pa1;
    logic [7:0]  pd0, pd1, ad0, ad1;
    logic        pv0, pv1, av0, av1, dn0, dn1, et0, et1, ea0, ea1;

    pixel_packet_receiver #(.PIXELS_PER_PACKET(PIX0), .AUDIO_BYTES(AUD0), .FRAME_PIXELS(FRAME)) dut0 (
        .clk(clk), .rst(rst), .axiiv(v0), .axiid(d0),
        .pixel_addr(pa0), .pixel_data(pd0), .pixel_valid(pv0),
        .audio_data(ad0), .audio_valid(av0), .packet_done(dn0),
        .err_truncated(et0), .err_addr(ea0)
    );

    pixel_packet_receiver #(.PIXELS_PER_PACKET(PIX1), .AUDIO_BYTES(AUD1), .FRAME_PIXELS(FRAME)) dut1 (
        .clk(clk), .rst(rst), .axiiv(v1), .axiid(d1),
        .pixel_addr(pa1), .pixel_data(pd1), .pixel_valid(pv1),
        .audio_data(ad1), .audio_valid(av1), .packet_done(dn1),
        .err_truncated(et1), .err_addr(ea1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ev_t;

    // Monitors only append; the checking process tracks how much it consumed.
    ev_t pix_q0[$], aud_q0[$], pix_q1[$], aud_q1[$];
    int  done_q0[$], trunc_q0[$], eaddr_q0[$];
    int  done_q1[$], trunc_q1[$], eaddr_q1[$];

    always @(posedge clk) begin
        #1;
        if (pv0) pix_q0.push_back('{int'(pa0), int'(pd0), cyc});
        if (av0) aud_q0.push_back('{0, int'(ad0), cyc});
        if (dn0) done_q0.push_back(cyc);
        if (et0) trunc_q0.push_back(cyc);
        if (ea0) eaddr_q0.push_back(cyc);
    end

    always @(posedge clk) begin
        #1;
        if (pv1) pix_q1.push_back('{int'(pa1), int'(pd1), cyc});
        if (av1) aud_q1.push_back('{0, int'(ad1), cyc});
        if (dn1) done_q1.push_back(cyc);
        if (et1) trunc_q1.push_back(cyc);
        if (ea1) eaddr_q1.push_back(cyc);
    end

    int n_asserts = 0;
    int n_fail    = 0;

    int pbase[2], abase[2], dbase[2], tbase[2], ebase[2];
    logic [7:0] payload[$];
    int start_cyc;
    int drop_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [1:0] d);
        if (sel) begin v1 = v; d1 = d; end
        else     begin v0 = v; d0 = d; end
    endtask

    // Sends the first n_dib dibits of header+payload, LS pair of each byte first.
    task automatic send(input bit sel, input logic [23:0] hdr, input int n_dib, input bit drop);
        logic [7:0] stream[$];
        logic [7:0] b;
        stream.push_back(hdr[23:16]);
        stream.push_back(hdr[15:8]);
        stream.push_back(hdr[7:0]);
        foreach (payload[i]) stream.push_back(payload[i]);
        for (int i = 0; i < n_dib; i++) begin
            b = stream[i / 4];
            drive(sel, 1'b1, b[2 * (i % 4) +: 2]);
            if (i == 0) start_cyc = cyc;
            @(negedge clk);
        end
        if (drop) begin
            drive(sel, 1'b0, 2'b00);
            drop_cyc = cyc;
            @(negedge clk);
        end
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(1, 255)));
    endtask

    // Reference: from header value and dibits sent, derive which writes, audio
    // bytes and pulses must have appeared, and when.
    task automatic verify(input bit sel, input logic [23:0] hdr, input int n_dib,
                          input bit dropped, input string tag);
        ev_t pq[$], aq[$];
        int  dq[$], tq[$], eq[$];
        int  pix_n, aud_n, c, exp_pix, exp_aud, idx;
        bit  good, exp_done, exp_trunc, exp_eaddr;
        if (sel) begin pq = pix_q1; aq = aud_q1; dq = done_q1; tq = trunc_q1; eq = eaddr_q1; end
        else     begin pq = pix_q0; aq = aud_q0; dq = done_q0; tq = trunc_q0; eq = eaddr_q0; end
        pix_n = sel ? PIX1 : PIX0;
        aud_n = sel ? AUD1 : AUD0;

        good      = (n_dib >= 12) && (hdr[23:17] == 7'd0) && (int'(hdr) < FRAME);
        c         = good ? (n_dib - 12) / 4 : 0;
        exp_pix   = (c < pix_n) ? c : pix_n;
        exp_aud   = (c > pix_n) ? c - pix_n : 0;
        if (exp_aud > aud_n) exp_aud = aud_n;
        exp_done  = good && (c >= pix_n + aud_n);
        exp_eaddr = (n_dib >= 12) && !good;
        exp_trunc = dropped && !exp_done && !exp_eaddr;

        check({tag, " writes"}, pq.size() - pbase[sel], exp_pix);
        for (int k = 0; k < exp_pix && pbase[sel] + k < pq.size(); k++) begin
            idx = pbase[sel] + k;
            check({tag, " addr"}, pq[idx].addr, (int'(hdr) + k) % FRAME);
            check({tag, " data"}, pq[idx].data, 32'(payload[k]));
            check({tag, " pix cycle"}, pq[idx].cyc, start_cyc + 16 + 4 * k);
        end
        check({tag, " audio count"}, aq.size() - abase[sel], exp_aud);
        for (int j = 0; j < exp_aud && abase[sel] + j < aq.size(); j++) begin
            idx = abase[sel] + j;
            check({tag, " audio data"}, aq[idx].data, 32'(payload[pix_n + j]));
            check({tag, " audio cycle"}, aq[idx].cyc, start_cyc + 16 + 4 * (pix_n + j));
        end
        check({tag, " done count"}, dq.size() - dbase[sel], 32'(exp_done));
        if (exp_done && dq.size() > dbase[sel])
            check({tag, " done cycle"}, dq[dbase[sel]], start_cyc + 16 + 4 * (pix_n + aud_n - 1));
        check({tag, " trunc count"}, tq.size() - tbase[sel], 32'(exp_trunc));
        if (exp_trunc && tq.size() > tbase[sel])
            check({tag, " trunc cycle"}, tq[tbase[sel]], drop_cyc + 1);
        check({tag, " err_addr count"}, eq.size() - ebase[sel], 32'(exp_eaddr));
        if (exp_eaddr && eq.size() > ebase[sel])
            check({tag, " err_addr cycle"}, eq[ebase[sel]], start_cyc + 12);

        pbase[sel] = pq.size();
        abase[sel] = aq.size();
        dbase[sel] = dq.size();
        tbase[sel] = tq.size();
        ebase[sel] = eq.size();
    endtask

    task automatic check_zero(input bit sel, input string tag);
        if (sel) begin
            check({tag, " pixel_addr"}, 32'(pa1), 0);  check({tag, " pixel_data"}, 32'(pd1), 0);
            check({tag, " pixel_valid"}, 32'(pv1), 0); check({tag, " audio_data"}, 32'(ad1), 0);
            check({tag, " audio_valid"}, 32'(av1), 0); check({tag, " packet_done"}, 32'(dn1), 0);
            check({tag, " err_truncated"}, 32'(et1), 0); check({tag, " err_addr"}, 32'(ea1), 0);
        end else begin
            check({tag, " pixel_addr"}, 32'(pa0), 0);  check({tag, " pixel_data"}, 32'(pd0), 0);
            check({tag, " pixel_valid"}, 32'(pv0), 0); check({tag, " audio_data"}, 32'(ad0), 0);
            check({tag, " audio_valid"}, 32'(av0), 0); check({tag, " packet_done"}, 32'(dn0), 0);
            check({tag, " err_truncated"}, 32'(et0), 0); check({tag, " err_addr"}, 32'(ea0), 0);
        end
    endtask

    initial begin
        logic [23:0] hdr;
        logic [1:0]  tail[4];
        int          n, full0, full1;

        full0 = 12 + 4 * (PIX0 + AUD0);
        full1 = 12 + 4 * (PIX1 + AUD1);
        for (int s = 0; s < 2; s++) begin
            pbase[s] = 0; abase[s] = 0; dbase[s] = 0; tbase[s] = 0; ebase[s] = 0;
        end

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 2'b00; d1 = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero(0, "reset0");
        check_zero(1, "reset1");

        // Dibit order, driven by hand: header 0, then 00,01,11,10 -> 0xB4.
        tail[0] = 2'b00; tail[1] = 2'b01; tail[2] = 2'b11; tail[3] = 2'b10;
        for (int i = 0; i < 16; i++) begin
            v0 = 1'b1;
            d0 = (i < 12) ? 2'b00 : tail[i - 12];
            if (i == 0) start_cyc = cyc;
            @(negedge clk);
        end
        v0 = 1'b0; drop_cyc = cyc; @(negedge clk);
        payload.delete(); payload.push_back(8'hB4);
        verify(0, 24'h000000, 16, 1, "order");

        // Nominal ramp packet at 0x000140, then strobe-low data hold.
        payload.delete();
        for (int k = 0; k < PIX0; k++) payload.push_back(8'(k % 256));
        send(0, 24'h000140, full0, 1);
        verify(0, 24'h000140, full0, 1, "nominal");
        check("hold pixel_addr", 32'(pa0), 639);
        check("hold pixel_data", 32'(pd0), 319 % 256);

        fill_random(PIX0);
        send(0, 24'd76700, full0, 1);
        verify(0, 24'd76700, full0, 1, "wrap");

        fill_random(PIX0);
        send(0, 24'h012C00, full0, 1);
        verify(0, 24'h012C00, full0, 1, "bad_addr");
        fill_random(PIX0);
        send(0, 24'h000000, full0, 1);
        verify(0, 24'h000000, full0, 1, "after_bad");

        fill_random(PIX0);
        send(0, 24'h800005, full0, 1);
        verify(0, 24'h800005, full0, 1, "bad_upper");

        // Truncation 2 dibits into pixel 5, next packet after one idle cycle.
        fill_random(PIX0);
        send(0, 24'd1000, 12 + 4 * 5 + 2, 1);
        verify(0, 24'd1000, 12 + 4 * 5 + 2, 1, "trunc_pix");
        fill_random(PIX0);
        send(0, 24'd2000, full0, 1);
        verify(0, 24'd2000, full0, 1, "after_trunc");

        send(0, 24'd3000, 7, 1);
        verify(0, 24'd3000, 7, 1, "trunc_hdr");

        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 3))
                0:       hdr = 24'($urandom_range(0, FRAME - 1));
                1:       hdr = 24'(FRAME - int'($urandom_range(1, 400)));
                2:       hdr = 24'($urandom_range(FRAME, 24'hFFFFFF));
                default: hdr = {7'($urandom_range(1, 127)), 17'($urandom_range(0, FRAME - 1))};
            endcase
            fill_random(PIX0);
            n = ($urandom_range(0, 1) == 1) ? full0 : int'($urandom_range(1, full0 - 1));
            send(0, hdr, n, 1);
            verify(0, hdr, n, 1, "random0");
        end

        // Audio-enabled receiver: full packet, then held audio byte.
        fill_random(PIX1 + AUD1);
        send(1, 24'd76798, full1, 1);
        verify(1, 24'd76798, full1, 1, "audio");
        check("hold audio_data", 32'(ad1), 32'(payload[PIX1 + AUD1 - 1]));

        // Reset on the edge that would complete the third audio byte.
        fill_random(PIX1 + AUD1);
        send(1, 24'd500, 12 + 4 * (PIX1 + 2) + 3, 0);
        rst = 1'b1;
        @(negedge clk);
        check_zero(1, "mid_rst");
        rst = 1'b0; v1 = 1'b0;
        @(negedge clk);
        verify(1, 24'd500, 12 + 4 * (PIX1 + 2) + 3, 0, "mid_rst");

        for (int r = 0; r < 4; r++) begin
            hdr = 24'($urandom_range(0, FRAME - 1));
            fill_random(PIX1 + AUD1);
            n = (r == 0 || $urandom_range(0, 1) == 1) ? full1 : int'($urandom_range(1, full1 - 1));
            send(1, hdr, n, 1);
            verify(1, hdr, n, 1, "random1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
